// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: single-outstanding fetch FSM filling a DEPTH-entry {pc, instr} FIFO.
// Optional misaligned-redirect trap compiled in with FETCH_ALIGN_CHECK_EN.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        align_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, cnt_after_push;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];

  logic        push, pop, can_push;
  logic        redir_bad, halted;
  logic [31:0] redir_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic halt_q, align_err_q;

  assign redir_pc  = redirect_pc;
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);

  // A misaligned redirect parks the fetcher until the next aligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q      <= 1'b0;
      align_err_q <= 1'b0;
    end else if (redirect_valid) begin
      halt_q <= redir_bad;
      if (redir_bad) begin
        align_err_q <= 1'b1;
      end
    end
  end

  assign halted    = halt_q;
  assign align_err = align_err_q;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign redir_bad = 1'b0;
  assign halted    = 1'b0;
  assign align_err = 1'b0;
`endif

  assign out_valid      = (count_q != '0);
  assign pop            = out_valid & out_ready & ~redirect_valid;
  assign can_push       = (count_q < DepthCnt) | pop;
  assign cnt_after_push = count_q + CntW'(1) - CntW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (redirect_valid) begin
      if (!redir_bad) begin
        fetch_pc_d = redir_pc;
      end
      unique case (state_q)
        StIdle, StReq: state_d = redir_bad ? StIdle : StReq;
        // A response arriving with the redirect is the stale one; nothing left to drop.
        StWait, StDrop: begin
          if (imem_rvalid) begin
            state_d = redir_bad ? StIdle : StReq;
          end else begin
            state_d = StDrop;
          end
        end
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!halted && (count_q < DepthCnt)) begin
            state_d = StReq;
          end
        end
        StReq: begin
          if (imem_ack) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (imem_rvalid && can_push) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (cnt_after_push < DepthCnt) ? StReq : StIdle;
          end
        end
        StDrop: begin
          if (imem_rvalid) begin
            state_d = halted ? StIdle : StReq;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign imem_req  = (state_q == StReq);
  assign imem_addr = imem_req ? fetch_pc_q : 32'h0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : 32'h0;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ((count_q < DepthCnt) || pop));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_q != '0));
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack && !redirect_valid) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: queue-level scoreboard plus a latency-configurable
// memory responder, with directed scenarios around fill, drain, redirect, wrap and alignment.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        align_err;

  instr_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected queue contents and fetch stream.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_instr[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_pc;
  logic        halted;
  logic        align_exp;
  // Memory responder state.
  int          lat = 1;
  logic        outstanding;
  logic        stale;
  logic [31:0] out_addr;
  int          cnt;
  logic        acc_now;
  logic [31:0] acc_addr_now;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_instr.delete();
    exp_pc      = RESET_PC;
    halted      = 1'b0;
    align_exp   = 1'b0;
    outstanding = 1'b0;
    stale       = 1'b0;
    cnt         = 0;
    acc_now     = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  // One clock cycle: compare at negedge, then advance model and memory past the rising edge.
  task automatic step();
    logic redir, bad, acc, rsp, pop;
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq_pc.size() != 0});
    if (mq_pc.size() != 0) begin
      chk("out_pc", out_pc, mq_pc[0]);
      chk("out_instr", out_instr, mq_instr[0]);
    end
    chk("align_err", {31'b0, align_err}, {31'b0, align_exp});
    chk("req_allowed", {31'b0, imem_req & (outstanding | halted | (mq_pc.size() >= DEPTH))}, 32'd0);
    if (imem_req) chk("imem_addr", imem_addr, exp_pc);

    redir = redirect_valid;
    bad   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    bad = redir && (redirect_pc[1:0] != 2'b00);
`endif
    acc          = imem_req && imem_ack && !redir;
    rsp          = imem_rvalid;
    pop          = (mq_pc.size() != 0) && out_ready && !redir;
    acc_now      = acc;
    acc_addr_now = imem_addr;

    @(posedge clk);
    #1;
    if (redir) begin
      mq_pc.delete();
      mq_instr.delete();
      if (outstanding && !rsp) stale = 1'b1;
      if (!bad) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        halted = 1'b0;
      end else begin
        halted    = 1'b1;
        align_exp = 1'b1;
      end
    end else begin
      if (pop) begin
        pop_log.push_back(mq_pc[0]);
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
      end
      if (rsp && !stale) begin
        mq_pc.push_back(out_addr);
        mq_instr.push_back(mem_word(out_addr));
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (rsp) outstanding = 1'b0;
    else if (outstanding && cnt > 0) cnt--;
    if (acc) begin
      outstanding = 1'b1;
      out_addr    = acc_addr_now;
      stale       = 1'b0;
      cnt         = lat - 1;
    end
    imem_rvalid = outstanding && (cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(out_addr) : 32'hDEAD_BEEF;
  endtask

  // Called just after a rising edge; leaves the DUT one cycle after release.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    model_reset();
    #2;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_align_err", {31'b0, align_err}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_cycle1_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("rel_cycle2_req", {31'b0, imem_req}, 32'd1);
    chk("rel_cycle2_addr", imem_addr, RESET_PC);
  endtask

  task automatic wait_accept(input string name, output logic [31:0] addr);
    int n = 0;
    addr = 32'hFFFF_FFFF;
    do begin
      step();
      n++;
    end while (!acc_now && n < 60);
    if (acc_now) begin
      addr = acc_addr_now;
    end else begin
      checks++;
      failures++;
      $display("FAIL %s: no request accepted within 60 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s: out_valid never rose within 60 cycles", name);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] acc_log[$];
    int n;

    @(posedge clk);
    #1;

    // Fill from reset with a stalled consumer.
    lat = 1;
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_now) acc_log.push_back(acc_addr_now);
    end
    chk("fill_req_count", acc_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("fill_addr", acc_log[i], 32'(4 * i));
    chk("fill_req_low", {31'b0, imem_req}, 32'd0);
    chk("fill_head_pc", out_pc, 32'h0);
    chk("fill_head_instr", out_instr, mem_word(32'h0));

    // Drain with steady ready: strictly sequential PCs.
    pop_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("drain_pop_ge8", {31'b0, pop_log.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("drain_pop_pc", pop_log[i], 32'(4 * i));

    // Redirect while waiting for 0x8: stale response dropped.
    lat = 3;
    do_reset();
    n = 0;
    do begin
      wait_accept("wait_addr8", a);
      n++;
    end while (a != 32'h8 && n < 4);
    chk("redir_wait_addr", a, 32'h8);
    redirect_to(32'h100);
    wait_accept("after_redir", a);
    chk("redir_next_req", a, 32'h100);
    wait_valid("redir_valid");
    chk("redir_first_pc", out_pc, 32'h100);
    chk("redir_first_instr", out_instr, mem_word(32'h100));

    // Redirect and pop in the same cycle with three entries.
    lat = 1;
    do_reset();
    n = 0;
    while (mq_pc.size() != 3 && n < 40) begin
      step();
      n++;
    end
    chk("three_entries", out_pc, 32'h0);
    out_ready = 1'b1;
    redirect_to(32'h40);
    out_ready = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    wait_accept("flush_req", a);
    chk("flush_next_req", a, 32'h40);
    wait_valid("flush_valid_rise");
    chk("flush_first_pc", out_pc, 32'h40);

    // Fetch address wraps at the top of the address space.
    out_ready = 1'b1;
    redirect_to(32'hFFFF_FFFC);
    wait_accept("wrap_a", a);
    chk("wrap_first", a, 32'hFFFF_FFFC);
    wait_accept("wrap_b", a);
    chk("wrap_second", a, 32'h0000_0000);

    // Misaligned redirect.
    redirect_to(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_err_set", {31'b0, align_err}, 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc_now) n++;
    end
    chk("halt_no_req", n, 32'd0);
    chk("halt_empty", {31'b0, out_valid}, 32'd0);
    redirect_to(32'h200);
    wait_accept("resume", a);
    chk("resume_addr", a, 32'h200);
    chk("align_err_sticky", {31'b0, align_err}, 32'd1);
`else
    wait_accept("misalign", a);
    chk("misalign_forced", a, 32'h100);
    chk("align_err_tied", {31'b0, align_err}, 32'd0);
`endif

    // Reset in the middle of an outstanding request.
    lat = 3;
    out_ready = 1'b0;
    wait_accept("pre_reset", a);
    do_reset();
    wait_accept("post_reset", a);
    chk("post_reset_addr", a, RESET_PC);
    for (int i = 0; i < 10; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries, power of two, range 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32 bits: fetch byte address, word-aligned.
REQ-007 SHALL have port imem_ack, input, 1 bit: memory accepts the request in this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1 bit: response word valid.
REQ-009 SHALL have port imem_rdata, input, 32 bits: response instruction word.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc, input, 32 bits: new fetch address.
REQ-012 SHALL have port out_valid, output, 1 bit: queue head valid toward decode/control.
REQ-013 SHALL have port out_ready, input, 1 bit: decode consumes the head.
REQ-014 SHALL have port out_instr, output, 32 bits: head instruction.
REQ-015 SHALL have port out_pc, output, 32 bits: head instruction address.
REQ-016 SHALL have port align_err, output, 1 bit: sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE (no request outstanding), REQ (imem_req high, awaiting imem_ack), WAIT (accepted, awaiting imem_rvalid), and DROP (awaiting a stale response to discard).
REQ-018 SHALL assert imem_req only in REQ, holding imem_addr stable until imem_ack; one outstanding request max.
REQ-019 SHALL go IDLE->REQ when occupancy < DEPTH, REQ->WAIT on imem_ack, and WAIT->IDLE on imem_rvalid while writing {fetch_pc, imem_rdata} to the tail and adding 4 to fetch_pc (wraps mod 2^32).
REQ-020 SHALL go from WAIT->REQ in the same cycle as the response when occupancy after push < DEPTH (back-to-back, one word per 2 cycles at zero memory latency).
REQ-021 SHALL present the head combinationally: out_valid = occupancy != 0; a pop occurs when out_valid && out_ready.
REQ-022 SHALL allow push and pop in the same cycle with occupancy unchanged, including at full; pointers wrap mod DEPTH.
REQ-023 SHALL never push when full and never pop when empty; out_instr/out_pc are don't-care when out_valid is low.
REQ-024 SHALL, on redirect_valid, flush all entries (out_valid low next cycle), ignore any same-cycle pop/push, and load fetch_pc with redirect_pc.
REQ-025 SHALL, on redirect: from IDLE or REQ, go to REQ with the new address (a REQ-state request is withdrawn even if imem_ack is high that cycle); from WAIT, go to DROP; from DROP, stay in DROP.
REQ-026 SHALL, in DROP, discard the data on imem_rvalid and go to REQ.
REQ-027 SHALL give redirect priority over every other event in the same cycle.

Reset
REQ-028 SHALL, while rst_n is low: state IDLE, fetch_pc = RESET_PC, occupancy 0, out_valid 0, imem_req 0, imem_addr 0, out_instr 0, out_pc 0, align_err 0.
REQ-029 SHALL, when reset is asserted mid-transaction, abandon the outstanding request with no DROP (the memory is reset alongside); the first request is issued in the second cycle after rst_n rises.

Configuration
REQ-030 SHALL compile misaligned-redirect checking only when macro FETCH_ALIGN_CHECK_EN is defined.
REQ-031 SHALL, with FETCH_ALIGN_CHECK_EN defined, treat a redirect with redirect_pc[1:0] != 0 as: set align_err (sticky until reset), flush the queue, and halt fetching in IDLE until a subsequent aligned redirect.
REQ-032 SHALL, without FETCH_ALIGN_CHECK_EN, tie align_err to 0 and force redirect_pc[1:0] to 2'b00.

Verification
REQ-033 SHALL check: reset release with imem_ack=1 and rvalid one cycle after ack, out_ready=0 -> requests at 0,4,8,12, then imem_req low with 4 entries queued.
REQ-034 SHALL check: full queue, out_ready=1 steady -> pops in PC order 0,4,8,..., no duplicates or skips.
REQ-035 SHALL check: redirect to 0x100 while in WAIT for 0x8 -> the 0x8 response is discarded, next request is 0x100, first out_pc is 0x100.
REQ-036 SHALL check: redirect and pop in the same cycle with 3 entries -> out_valid is 0 next cycle and no entry survives.
REQ-037 SHALL check: fetch_pc at 0xFFFF_FFFC -> next request address is 0x0000_0000.
REQ-038 SHALL check: with FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> align_err=1 and no request; a later redirect to 0x200 -> fetch resumes with align_err still 1.
